// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared encodings for the MEM-stage data-memory access path.
//   Size codes carried from EX/MEM, FSM state type, byte-enable patterns.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;   // 2'b11 is also handled as a word

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// dmem_if: request/acknowledge data-memory port.
//   master (MEM stage): dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be out;
//                       dmem_rdata, dmem_ack in.
//   slave  (memory)   : the reverse directions.
interface dmem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage_align.sv
// mem_align: combinational lane handling for the MEM stage.
//   Store side: st_off/st_size/st_data -> st_wdata (lane replicated), st_be,
//               misaligned.
//   Load side : ld_off/ld_size/ld_signed/ld_rdata -> ld_data (lane selected,
//               zero/sign extended).
// Sub-word support is compiled in only when SUBWORD_ACCESS_EN is defined;
// otherwise every access is a full word.
module mem_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic        misaligned,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

`ifdef SUBWORD_ACCESS_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata   = st_data;
        st_be      = BE_WORD;
        misaligned = 1'b0;
        case (st_size)
            SIZE_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_off;
            end
            SIZE_HALF: begin
                st_wdata   = {2{st_data[15:0]}};
                st_be      = st_off[1] ? BE_HALF_HI : BE_HALF_LO;
                misaligned = st_off[0];
            end
            default: misaligned = (st_off != 2'b00);
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default:   ld_data = ld_rdata;
        endcase
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{st_size, ld_off, ld_size, ld_signed};
    assign st_wdata   = st_data;
    assign st_be      = BE_WORD;
    assign misaligned = (st_off != 2'b00);
    assign ld_data    = ld_rdata;
`endif

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-memory access unit.
//   clk, reset           : pipeline clock, async active-high reset
//   MEM_MemRead/Write    : access request from EX/MEM (write wins)
//   MEM_MemSize/Signed   : access width and load extension
//   MEM_ALUResult        : byte address; MEM_WriteData: store operand
//   dmem (dmem_if.master): one req/ack transaction per access
//   MEM_ReadData         : formatted load result to MEM/WB
//   MEM_Stall            : pipeline hold while a transaction is outstanding
//   MEM_Misaligned       : one-cycle alignment fault (IDLE only)
//   MEM_BusError         : one-cycle timeout fault (first DONE cycle)
// Parameter TIMEOUT_CYCLES: WAIT cycles without ack before abort (1..65535).
// Optional macro SUBWORD_ACCESS_EN enables byte/half accesses.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         MEM_MemRead,
    input  logic         MEM_MemWrite,
    input  logic [1:0]   MEM_MemSize,
    input  logic         MEM_MemSigned,
    input  logic [31:0]  MEM_ALUResult,
    input  logic [31:0]  MEM_WriteData,
    dmem_if.master       dmem,
    output logic [31:0]  MEM_ReadData,
    output logic         MEM_Stall,
    output logic         MEM_Misaligned,
    output logic         MEM_BusError
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    mem_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;

    logic        access;
    logic        misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;

    assign access = MEM_MemRead | MEM_MemWrite;

    // Store side looks at the live EX/MEM inputs; load side uses the values
    // latched at launch so the result matches the request actually issued.
    mem_align u_align (
        .st_off     (MEM_ALUResult[1:0]),
        .st_size    (MEM_MemSize),
        .st_data    (MEM_WriteData),
        .st_wdata   (st_wdata),
        .st_be      (st_be),
        .misaligned (misaligned),
        .ld_off     (off_q),
        .ld_size    (size_q),
        .ld_signed  (sgn_q),
        .ld_rdata   (dmem.dmem_rdata),
        .ld_data    (ld_data)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        we_d           = we_q;
        off_d          = off_q;
        size_d         = size_q;
        sgn_d          = sgn_q;
        rdata_d        = rdata_q;
        bus_err_d      = 1'b0;
        MEM_Stall      = 1'b0;
        MEM_Misaligned = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        MEM_Misaligned = 1'b1;
                    end else begin
                        MEM_Stall = 1'b1;
                        addr_d    = {MEM_ALUResult[31:2], 2'b00};
                        wdata_d   = st_wdata;
                        be_d      = st_be;
                        we_d      = MEM_MemWrite;
                        off_d     = MEM_ALUResult[1:0];
                        size_d    = MEM_MemSize;
                        sgn_d     = MEM_MemSigned;
                        cnt_d     = '0;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                MEM_Stall = 1'b1;
                if (dmem.dmem_ack) begin
                    rdata_d = we_q ? '0 : ld_data;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == TIMEOUT_LIMIT) begin
                        rdata_d   = '0;
                        bus_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            off_q     <= off_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dmem.dmem_req   = (state_q == ST_WAIT);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    // A misaligned access reports zero data for its fault cycle only; the
    // registered result is otherwise held until the next WAIT->DONE.
    assign MEM_ReadData = MEM_Misaligned ? '0 : rdata_q;
    assign MEM_BusError = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized self-checking bench for mem_access_stage
// with a transaction-level reference model (TIMEOUT_CYCLES = 4).
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    localparam int unsigned TO = 4;
`ifdef SUBWORD_ACCESS_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_MemRead, MEM_MemWrite, MEM_MemSigned;
    logic [1:0]  MEM_MemSize;
    logic [31:0] MEM_ALUResult, MEM_WriteData, MEM_ReadData;
    logic        MEM_Stall, MEM_Misaligned, MEM_BusError;
    int          n_checks = 0;
    int          n_errors = 0;

    dmem_if bus();

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_MemWrite   (MEM_MemWrite),
        .MEM_MemSize    (MEM_MemSize),
        .MEM_MemSigned  (MEM_MemSigned),
        .MEM_ALUResult  (MEM_ALUResult),
        .MEM_WriteData  (MEM_WriteData),
        .dmem           (bus),
        .MEM_ReadData   (MEM_ReadData),
        .MEM_Stall      (MEM_Stall),
        .MEM_Misaligned (MEM_Misaligned),
        .MEM_BusError   (MEM_BusError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_word(input logic [1:0] size);
        return !SUB || size >= 2'd2;
    endfunction

    function automatic bit m_mis(input logic [1:0] size, input int unsigned off);
        if (m_word(size)) return off != 0;
        if (size == 2'd1) return (off % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input int unsigned off);
        if (m_word(size)) return 4'hF;
        if (size == 2'd0) return 4'(1 << off);
        return 4'(3 << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (m_word(size)) return wd;
        if (size == 2'd0) return (wd % 256) * 32'h0101_0101;
        return (wd % 65536) * 32'h0001_0001;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn,
                                           input int unsigned off, input logic [31:0] rd);
        logic [31:0] v;
        if (m_word(size)) return rd;
        v = rd >> (8 * off);
        if (size == 2'd0) begin
            v = v % 256;
            if (sgn && v >= 128) v = v - 256;
        end else begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        MEM_MemRead   = 1'b0;
        MEM_MemWrite  = 1'b0;
        MEM_MemSize   = 2'b00;
        MEM_MemSigned = 1'b0;
        MEM_ALUResult = '0;
        MEM_WriteData = '0;
    endtask

    // One access; the memory acks in WAIT cycle k (0-based), never if k >= TO.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdat, input int unsigned k);
        int unsigned off = addr % 4;
        int unsigned stalls = 0;
        int unsigned widx = 0;
        int unsigned exp_stalls;
        bit          done = 1'b0;
        bit          exp_to;
        logic [31:0] exp_rd;

        exp_to     = (k >= TO);
        exp_stalls = exp_to ? TO + 1 : k + 2;
        exp_rd     = (exp_to || wr) ? 32'd0 : m_load(size, sgn, off, rdat);

        @(posedge clk); #1;
        MEM_MemRead   = rd;
        MEM_MemWrite  = wr;
        MEM_MemSize   = size;
        MEM_MemSigned = sgn;
        MEM_ALUResult = addr;
        MEM_WriteData = wd;
        @(negedge clk);

        if (m_mis(size, off)) begin
            check("mis_flag",  {31'd0, MEM_Misaligned}, 32'd1);
            check("mis_stall", {31'd0, MEM_Stall}, 32'd0);
            check("mis_req",   {31'd0, bus.dmem_req}, 32'd0);
            check("mis_rdata", MEM_ReadData, 32'd0);
            idle_inputs();
            @(negedge clk);
            check("mis_req_after", {31'd0, bus.dmem_req}, 32'd0);
            return;
        end

        check("launch_req", {31'd0, bus.dmem_req}, 32'd0);
        check("launch_mis", {31'd0, MEM_Misaligned}, 32'd0);

        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (!MEM_Stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (bus.dmem_req) begin
                    check("addr",  bus.dmem_addr, addr - off);
                    check("we",    {31'd0, bus.dmem_we}, {31'd0, wr});
                    check("be",    {28'd0, bus.dmem_be}, {28'd0, m_be(size, off)});
                    check("wdata", bus.dmem_wdata, m_wdata(size, wd));
                    if (widx == k) begin
                        bus.dmem_ack   = 1'b1;
                        bus.dmem_rdata = rdat;
                    end
                    widx++;
                end
                @(posedge clk); #1;
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = $urandom;
            end
        end

        check("done_reached", {31'd0, done}, 32'd1);
        check("stall_cycles", stalls, exp_stalls);
        check("rdata",        MEM_ReadData, exp_rd);
        check("bus_error",    {31'd0, MEM_BusError}, {31'd0, exp_to});
        check("done_req",     {31'd0, bus.dmem_req}, 32'd0);

        // Stray ack in DONE must not disturb anything.
        idle_inputs();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = ~exp_rd;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("hold_rdata",   MEM_ReadData, exp_rd);
        check("bus_err_once", {31'd0, MEM_BusError}, 32'd0);
        check("no_relaunch",  {31'd0, bus.dmem_req | MEM_Stall}, 32'd0);
    endtask

    task automatic reset_mid_wait();
        @(posedge clk); #1;
        MEM_MemWrite  = 1'b1;
        MEM_MemSize   = 2'b10;
        MEM_ALUResult = 32'h24;
        MEM_WriteData = 32'h1234_5678;
        @(negedge clk);                 // IDLE launch
        @(negedge clk);                 // WAIT 1
        @(negedge clk);                 // WAIT 2
        check("rst_pre_req", {31'd0, bus.dmem_req}, 32'd1);
        check("rst_pre_we",  {31'd0, bus.dmem_we}, 32'd1);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("rst_req",   {31'd0, bus.dmem_req}, 32'd0);
        check("rst_we",    {31'd0, bus.dmem_we}, 32'd0);
        check("rst_addr",  bus.dmem_addr, 32'd0);
        check("rst_wdata", bus.dmem_wdata, 32'd0);
        check("rst_be",    {28'd0, bus.dmem_be}, 32'd0);
        check("rst_rdata", MEM_ReadData, 32'd0);
        check("rst_flags", {29'd0, MEM_Stall, MEM_Misaligned, MEM_BusError}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_rdata", MEM_ReadData, 32'd0);
        check("late_ack_req",   {31'd0, bus.dmem_req | MEM_Stall}, 32'd0);
    endtask

    initial begin
        logic        rd, wr, sg;
        logic [1:0]  sz;
        logic [31:0] ad;

        reset          = 1'b1;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        idle_inputs();
        #12;
        check("reset_req",   {31'd0, bus.dmem_req}, 32'd0);
        check("reset_rdata", MEM_ReadData, 32'd0);
        check("reset_flags", {29'd0, MEM_Stall, MEM_Misaligned, MEM_BusError}, 32'd0);
        check("reset_bus",   bus.dmem_addr | bus.dmem_wdata | {28'd0, bus.dmem_be}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,  32'hDEAD_BEEF, 0);
        check("lw_literal", MEM_ReadData, 32'hDEAD_BEEF);
        do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hA5, 32'h0, 1);
        do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,  32'h8000_0000, 0);
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,  32'h8000_0000, 2);
        do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h02, 32'h0,  32'h8001_0000, 0);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0,  32'h0, 0);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,  32'hCAFE_F00D, 99);
        do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h77, 32'h5555_5555, 0);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,  32'hDEAD_BEEF, 3);
        reset_mid_wait();

        // Randomized cases
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            sz = 2'($urandom);
            sg = 1'($urandom);
            ad = $urandom;
            if ($urandom_range(0, 2) != 0) ad[1:0] = 2'b00;
            do_access(rd, wr, sz, sg, ad, $urandom, $urandom, $urandom_range(0, 6));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
